// File: rtl/rvv_insn_queue.sv
// rvv_insn_queue: FWFT circular instruction queue to the vector core; define RVV_QUEUE_BYPASS_EN for a zero-latency empty-queue bypass
module rvv_insn_queue #(
  parameter int INSN_WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INSN_WIDTH-1:0] insn_in,
  input  logic                  insn_valid_in,
  output logic                  insn_ready_out,
  output logic [INSN_WIDTH-1:0] insn_out,
  output logic                  insn_valid_out,
  input  logic                  insn_ready_in,
  input  logic                  flush_in,
  input  logic                  proc_idle_in,
  output logic [CNT_WIDTH-1:0]  occupancy,
  output logic                  rvv_idle
);
  localparam int AW = $clog2(DEPTH);
  logic [INSN_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic empty, full, take, push, pop;
  assign empty = occupancy == '0;
  assign full = occupancy == CNT_WIDTH'(DEPTH);
  assign insn_ready_out = rst && !flush_in && !full;
`ifdef RVV_QUEUE_BYPASS_EN
  assign insn_valid_out = rst && (empty ? (!flush_in && insn_valid_in) : 1'b1);
  assign insn_out = empty ? insn_in : mem[rd_ptr];
  assign take = rst && empty && !flush_in && insn_valid_in && insn_ready_in;
`else
  assign insn_valid_out = rst && !empty;
  assign insn_out = mem[rd_ptr];
  assign take = 1'b0;
`endif
  assign push = insn_valid_in && insn_ready_out && !take;
  assign pop = insn_valid_out && insn_ready_in && !take;
  assign rvv_idle = empty && proc_idle_in && !insn_valid_in;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= insn_in;
  always_ff @(posedge clk) begin
    if (!rst || flush_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      occupancy <= occupancy + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
    end
  end
endmodule

// File: tb/tb_rvv_insn_queue.sv
// tb_rvv_insn_queue: randomized and directed checks of rvv_insn_queue against a queue-based model
module tb_rvv_insn_queue;
  localparam int W = 32;
  localparam int D = 4;
  localparam int CW = $clog2(D) + 1;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [W-1:0] insn_in = '0;
  logic insn_valid_in = 1'b0;
  logic insn_ready_out;
  logic [W-1:0] insn_out;
  logic insn_valid_out;
  logic insn_ready_in = 1'b0;
  logic flush_in = 1'b0;
  logic proc_idle_in = 1'b1;
  logic [CW-1:0] occupancy;
  logic rvv_idle;
  int errors = 0;
  int checks = 0;
  logic [W-1:0] q[$];
  logic [W-1:0] popped[$];

  rvv_insn_queue #(.INSN_WIDTH(W), .DEPTH(D), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .insn_in(insn_in), .insn_valid_in(insn_valid_in),
    .insn_ready_out(insn_ready_out), .insn_out(insn_out), .insn_valid_out(insn_valid_out),
    .insn_ready_in(insn_ready_in), .flush_in(flush_in), .proc_idle_in(proc_idle_in),
    .occupancy(occupancy), .rvv_idle(rvv_idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic f, input logic v, input logic [W-1:0] d,
                      input logic rd, input logic p);
    logic er, ev;
    logic [W-1:0] eo;
    @(negedge clk);
    rst = r; flush_in = f; insn_valid_in = v; insn_in = d; insn_ready_in = rd; proc_idle_in = p;
    #1;
    er = r && !f && q.size() < D;
`ifdef RVV_QUEUE_BYPASS_EN
    ev = r && (q.size() != 0 || (!f && v));
`else
    ev = r && q.size() != 0;
`endif
    eo = q.size() != 0 ? q[0] : d;
    chk("ready", W'(insn_ready_out), W'(er));
    chk("valid", W'(insn_valid_out), W'(ev));
    if (ev) chk("data", insn_out, eo);
    chk("occ", W'(occupancy), W'(q.size()));
    chk("idle", W'(rvv_idle), W'(q.size() == 0 && p && !v));
    if (insn_valid_out && rd) popped.push_back(insn_out);
    @(posedge clk);
    if (!r || f) q.delete();
    else begin
      if (!(q.size() == 0 && ev && rd)) begin
        if (ev && rd) void'(q.pop_front());
        if (v && er) q.push_back(d);
      end
    end
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 32'h11, 1, 1);
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 32'hA1 + i, 0, 1);
    #1;
    chk("full_occ", W'(occupancy), 4);
    chk("full_ready", W'(insn_ready_out), 0);
    chk("full_head", insn_out, 32'hA1);
    step(1, 0, 1, 32'hB5, 1, 1);
    #1;
    chk("fullpp_occ", W'(occupancy), 3);
    chk("fullpp_head", insn_out, 32'hA2);
    popped.delete();
    step(1, 1, 1, 32'hC1, 0, 1);
    #1;
    chk("flush_occ", W'(occupancy), 0);
    chk("flush_valid", W'(insn_valid_out), 0);
    step(1, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 1, 1);
    chk("flush_drop", W'(popped.size()), 0);
    step(1, 0, 1, 32'h01, 0, 1);
    step(1, 0, 1, 32'h02, 0, 1);
    for (int i = 3; i <= 6; i++) step(1, 0, 1, W'(i), 1, 1);
    step(1, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 1, 1);
    #1;
    chk("wrap_cnt", W'(popped.size()), 6);
    for (int i = 0; i < 6 && i < popped.size(); i++) chk("wrap_order", popped[i], W'(i + 1));
    chk("wrap_occ", W'(occupancy), 0);
    step(1, 0, 1, 32'hE1, 0, 1);
    step(1, 0, 1, 32'hE2, 0, 1);
    step(0, 0, 1, 32'hE3, 1, 1);
    #1;
    chk("rst_occ", W'(occupancy), 0);
    chk("rst_valid", W'(insn_valid_out), 0);
    step(1, 0, 0, 0, 0, 1);
    #1;
    chk("rst_idle", W'(rvv_idle), 1);
    popped.delete();
    step(1, 0, 1, 32'hD1, 1, 1);
    #1;
`ifdef RVV_QUEUE_BYPASS_EN
    chk("byp_occ", W'(occupancy), 0);
    chk("byp_cnt", W'(popped.size()), 1);
`else
    chk("nobyp_occ1", W'(occupancy), 1);
    chk("nobyp_head", insn_out, 32'hD1);
    step(1, 0, 0, 0, 1, 1);
    #1;
    chk("nobyp_occ0", W'(occupancy), 0);
`endif
    if (popped.size() > 0) chk("d1_emitted", popped[0], 32'hD1);
    else chk("d1_emitted", 32'hFFFF_FFFF, 32'hD1);
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 49) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6,
           $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rvv_insn_queue.md
RVV_INSN_QUEUE -- requirements
Module: rvv_insn_queue

Interface
REQ-001 SHALL have parameter INSN_WIDTH, default 32, width of one vector instruction word.
REQ-002 SHALL have parameter DEPTH, default 4, queue entries; power of two, >= 2.
REQ-003 SHALL have parameter CNT_WIDTH, default $clog2(DEPTH)+1, occupancy counter width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port insn_in  input  INSN_WIDTH  instruction from scalar core.
REQ-007 SHALL have port insn_valid_in  input  1  insn_in valid.
REQ-008 SHALL have port insn_ready_out  output  1  queue accepts insn_in this cycle.
REQ-009 SHALL have port insn_out  output  INSN_WIDTH  head instruction to vector core.
REQ-010 SHALL have port insn_valid_out  output  1  insn_out valid.
REQ-011 SHALL have port insn_ready_in  input  1  vector core consumes insn_out this cycle.
REQ-012 SHALL have port flush_in  input  1  discard all queued instructions.
REQ-013 SHALL have port proc_idle_in  input  1  vector core reports no instruction in flight.
REQ-014 SHALL have port occupancy  output  CNT_WIDTH  stored entry count.
REQ-015 SHALL have port rvv_idle  output  1  queue empty and vector core idle.

Function
REQ-016 SHALL be a circular buffer: write pointer, read pointer, occupancy counter; pointers wrap DEPTH-1 -> 0.
REQ-017 SHALL push when insn_valid_in && insn_ready_out; pop when insn_valid_out && insn_ready_in.
REQ-018 SHALL drive insn_ready_out = (occupancy != DEPTH) && !flush_in; no push while full even if a pop occurs the same cycle.
REQ-019 SHALL drive insn_valid_out = (occupancy != 0), insn_out = entry at read pointer (first-word-fall-through).
REQ-020 SHALL update occupancy +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-021 SHALL, with no bypass, present a pushed instruction on insn_out no earlier than the cycle after the push (latency 1).
REQ-022 SHALL, on flush_in high, zero both pointers and occupancy at the next edge, dropping any same-cycle push and pop; insn_valid_out still reflects pre-flush state in the flush cycle.
REQ-023 SHALL hold insn_out stable while insn_valid_out && !insn_ready_in.
REQ-024 SHALL drive rvv_idle = (occupancy == 0) && proc_idle_in && !insn_valid_in, combinationally.
REQ-025 SHALL preserve FIFO order across pointer wrap-around.

Reset
REQ-026 SHALL, when rst low at a rising edge, set pointers and occupancy to 0; insn_valid_out 0, insn_ready_out 0 during reset cycle, 1 the cycle after rst rises.
REQ-027 SHALL treat reset mid-operation as a flush: all stored entries lost, no partial pop.
REQ-028 SHALL not reset storage array contents; insn_out is don't-care while insn_valid_out is 0.

Configuration
REQ-029 SHALL, with macro RVV_QUEUE_BYPASS_EN defined, when occupancy == 0 and !flush_in, drive insn_valid_out = insn_valid_in and insn_out = insn_in combinationally; if insn_ready_in is high the instruction is consumed without being stored (latency 0, occupancy unchanged).
REQ-030 SHALL, without RVV_QUEUE_BYPASS_EN, have no combinational path from insn_in/insn_valid_in to insn_out/insn_valid_out.

Verification (DEPTH=4)
REQ-031 Push 0xA1,0xA2,0xA3,0xA4 with insn_ready_in=0 -> occupancy 4, insn_ready_out 0, insn_out 0xA1.
REQ-032 Full queue, push 0xB5 and pop same cycle -> 0xB5 rejected, occupancy 3, next insn_out 0xA2.
REQ-033 Six pushes/pops interleaved across wrap (0x01..0x06) -> popped order 0x01..0x06, occupancy returns to 0.
REQ-034 Occupancy 3, flush_in=1 with push 0xC1 -> next cycle occupancy 0, insn_valid_out 0, 0xC1 never emitted.
REQ-035 Occupancy 2, rst low one cycle -> occupancy 0, insn_valid_out 0; rvv_idle 1 once rst high, proc_idle_in 1, insn_valid_in 0.
REQ-036 Empty, push 0xD1 with insn_ready_in=1 -> with RVV_QUEUE_BYPASS_EN: insn_out 0xD1 same cycle, occupancy stays 0; without: insn_out 0xD1 next cycle, occupancy 1 then 0.
